hyperram_arbiter: RTL and testbench

- Two-port Wishbone-classic arbiter sharing the single HyperRAM wrapper port between requesters, e.g. port 0 = CPU/GROM path, port 1 = video/DMA.
- Latches the winning request into hold registers and drives the wrapper from those registers.
- Routes the wrapper's ack back to the winner only.
- Provides fixed-priority with a starvation limit, or round-robin arbitration.

---
 rtl/hyperram_arbiter_if.sv | 49 ++++
 rtl/hyperram_arbiter.sv | 96 +++++++++
 tb/tb_hyperram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperram_arbiter_if.sv
// Wishbone-classic bundle: two requester ports and the single HyperRAM wrapper port.
interface hyperram_arbiter_if;
  logic [31:2] s0_adr_i;
  logic [31:0] s0_dat_i;
  logic [31:0] s0_dat_o;
  logic        s0_we_i;
  logic [3:0]  s0_sel_i;
  logic        s0_stb_i;
  logic        s0_cyc_i;
  logic        s0_ack_o;

  logic [31:2] s1_adr_i;
  logic [31:0] s1_dat_i;
  logic [31:0] s1_dat_o;
  logic        s1_we_i;
  logic [3:0]  s1_sel_i;
  logic        s1_stb_i;
  logic        s1_cyc_i;
  logic        s1_ack_o;

  logic [31:2] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic        m_stb_o;
  logic        m_cyc_o;
  logic        m_ack_i;

  // Arbiter side: slave to both requesters, master to the wrapper.
  modport slave (
    input  s0_adr_i, s0_dat_i, s0_we_i, s0_sel_i, s0_stb_i, s0_cyc_i,
    output s0_dat_o, s0_ack_o,
    input  s1_adr_i, s1_dat_i, s1_we_i, s1_sel_i, s1_stb_i, s1_cyc_i,
    output s1_dat_o, s1_ack_o,
    output m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
    input  m_dat_i, m_ack_i
  );

  // Environment side: the requesters and the wrapper.
  modport master (
    output s0_adr_i, s0_dat_i, s0_we_i, s0_sel_i, s0_stb_i, s0_cyc_i,
    input  s0_dat_o, s0_ack_o,
    output s1_adr_i, s1_dat_i, s1_we_i, s1_sel_i, s1_stb_i, s1_cyc_i,
    input  s1_dat_o, s1_ack_o,
    input  m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/hyperram_arbiter.sv
// Two-port Wishbone-classic arbiter in front of the HyperRAM wrapper.
// Fixed priority with a port-1 starvation limit, or round-robin.
module hyperram_arbiter #(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned MAX_CONSEC  = 4
) (
  input  logic              clk,
  input  logic              reset,
  hyperram_arbiter_if.slave bus,
  output logic              busy_o,
  output logic              grant_o
);
  localparam int unsigned CONSEC_W = (MAX_CONSEC < 2) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_CONSEC);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state;
  logic                last_grant;
  logic                aborted;
  logic [CONSEC_W-1:0] consec;
  logic                req0;
  logic                req1;
  logic                pick;
  logic                win_cyc;

  assign req0    = bus.s0_stb_i & bus.s0_cyc_i;
  assign req1    = bus.s1_stb_i & bus.s1_cyc_i;
  assign win_cyc = grant_o ? bus.s1_cyc_i : bus.s0_cyc_i;

  // Winner selection; a lone requester always wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
      if (ROUND_ROBIN != 0) pick = ~last_grant;
      else                  pick = (MAX_CONSEC != 0) && (consec == CONSEC_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus.m_adr_o <= '0;
      bus.m_dat_o <= '0;
      bus.m_we_o  <= 1'b0;
      bus.m_sel_o <= '0;
      bus.m_stb_o <= 1'b0;
      bus.m_cyc_o <= 1'b0;
      busy_o      <= 1'b0;
      grant_o     <= 1'b0;
      last_grant  <= 1'b1;
      consec      <= '0;
      aborted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state       <= BUSY;
            bus.m_adr_o <= pick ? bus.s1_adr_i : bus.s0_adr_i;
            bus.m_dat_o <= pick ? bus.s1_dat_i : bus.s0_dat_i;
            bus.m_we_o  <= pick ? bus.s1_we_i  : bus.s0_we_i;
            bus.m_sel_o <= pick ? bus.s1_sel_i : bus.s0_sel_i;
            bus.m_stb_o <= 1'b1;
            bus.m_cyc_o <= 1'b1;
            busy_o      <= 1'b1;
            grant_o     <= pick;
            last_grant  <= pick;
            // Count port-0 wins only while port 1 is left waiting.
            if (!pick && req1) begin
              if (consec != CONSEC_MAX) consec <= consec + CONSEC_W'(1);
            end else begin
              consec <= '0;
            end
          end
        end
        BUSY: begin
          // The wrapper cannot cancel, so an abort only swallows the ack.
          if (bus.m_ack_i) begin
            state       <= IDLE;
            bus.m_stb_o <= 1'b0;
            bus.m_cyc_o <= 1'b0;
            busy_o      <= 1'b0;
            aborted     <= 1'b0;
          end else if (!win_cyc) begin
            aborted <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.s0_ack_o = (state == BUSY) && !grant_o && bus.m_ack_i && !aborted;
  assign bus.s1_ack_o = (state == BUSY) &&  grant_o && bus.m_ack_i && !aborted;
  assign bus.s0_dat_o = bus.m_dat_i;
  assign bus.s1_dat_o = bus.m_dat_i;
endmodule

// File: tb/tb_hyperram_arbiter.sv
// Bench for hyperram_arbiter: three instances (round-robin, fixed-priority limit 4,
// fixed-priority unlimited) share one set of requester and wrapper stimulus.
module tb_hyperram_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:2] s0_adr, s1_adr;
  logic [31:0] s0_dat, s1_dat, m_dat;
  logic        s0_we, s1_we, s0_stb, s1_stb, s0_cyc, s1_cyc, m_ack;
  logic [3:0]  s0_sel, s1_sel;

  logic [2:0]  m_stb_v, m_cyc_v, m_we_v, busy_v, grant_v, s0_ack_v, s1_ack_v;
  logic [31:2] m_adr_v   [3];
  logic [31:0] m_dato_v  [3];
  logic [31:0] s0_dato_v [3];
  logic [31:0] s1_dato_v [3];
  logic [3:0]  m_sel_v   [3];

  // Instance 0: round-robin; 1: fixed priority, limit 4; 2: fixed priority, no limit.
  for (genvar i = 0; i < 3; i++) begin : g_dut
    hyperram_arbiter_if bus ();
    hyperram_arbiter #(
      .ROUND_ROBIN((i == 0) ? 1 : 0),
      .MAX_CONSEC ((i == 1) ? 4 : 0)
    ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .busy_o (busy_v[i]),
      .grant_o(grant_v[i])
    );
    assign bus.s0_adr_i = s0_adr;
    assign bus.s0_dat_i = s0_dat;
    assign bus.s0_we_i  = s0_we;
    assign bus.s0_sel_i = s0_sel;
    assign bus.s0_stb_i = s0_stb;
    assign bus.s0_cyc_i = s0_cyc;
    assign bus.s1_adr_i = s1_adr;
    assign bus.s1_dat_i = s1_dat;
    assign bus.s1_we_i  = s1_we;
    assign bus.s1_sel_i = s1_sel;
    assign bus.s1_stb_i = s1_stb;
    assign bus.s1_cyc_i = s1_cyc;
    assign bus.m_dat_i  = m_dat;
    assign bus.m_ack_i  = m_ack;
    assign m_stb_v[i]   = bus.m_stb_o;
    assign m_cyc_v[i]   = bus.m_cyc_o;
    assign m_we_v[i]    = bus.m_we_o;
    assign m_adr_v[i]   = bus.m_adr_o;
    assign m_dato_v[i]  = bus.m_dat_o;
    assign m_sel_v[i]   = bus.m_sel_o;
    assign s0_ack_v[i]  = bus.s0_ack_o;
    assign s1_ack_v[i]  = bus.s1_ack_o;
    assign s0_dato_v[i] = bus.s0_dat_o;
    assign s1_dato_v[i] = bus.s1_dat_o;
  end

  typedef struct {
    bit          port;
    logic [31:2] adr;
    logic [31:0] dat;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int unsigned delay;
    bit          exp_grant;
    bit          exp_ack0;
    bit          exp_ack1;
  } vec_t;

  vec_t tbl [4];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input bit p, input logic [31:2] adr, input logic [31:0] dat,
                            input bit we, input logic [3:0] sel, input bit on);
    if (p) begin
      s1_adr = adr; s1_dat = dat; s1_we = we; s1_sel = sel; s1_stb = on; s1_cyc = on;
    end else begin
      s0_adr = adr; s0_dat = dat; s0_we = we; s0_sel = sel; s0_stb = on; s0_cyc = on;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    drive_port(1'b0, '0, '0, 1'b0, '0, 1'b0);
    drive_port(1'b1, '0, '0, 1'b0, '0, 1'b0);
    m_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Random-phase state for the fixed-priority (limit 4) reference model.
  bit          prev_stb, prev_ack, cur_port, r0, r1, eg, a0, a1, ack_seen0, ack_seen1;
  int          run0, wait_cnt;
  logic [66:0] lat;

  initial begin
    drive_port(1'b0, '0, '0, 1'b0, '0, 1'b0);
    drive_port(1'b1, '0, '0, 1'b0, '0, 1'b0);
    m_ack = 1'b0;
    m_dat = '0;
    tbl[0] = '{1'b0, 30'h0000100, 32'h00000000, 1'b0, 4'hF, 32'h12345678, 6, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 30'h3FFFFFFF, 32'hDEADBEEF, 1'b1, 4'h3, 32'hA5A5A5A5, 1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 30'h0000000, 32'hFFFFFFFF, 1'b1, 4'h1, 32'h00000000, 2, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 30'h1555555, 32'h0F0F0F0F, 1'b0, 4'h8, 32'hFEDCBA98, 3, 1'b1, 1'b0, 1'b1};

    // Asynchronous reset, checked before the first clock edge.
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ctl%0d", i), 96'({m_stb_v[i], m_cyc_v[i], busy_v[i], grant_v[i]}), 96'(0));
      chk($sformatf("rst_bus%0d", i), 96'({m_adr_v[i], m_dato_v[i], m_we_v[i], m_sel_v[i]}), 96'(0));
    end
    tick();
    reset = 1'b0;
    tick();

    // Single-port transactions from the vector table.
    for (int k = 0; k < 4; k++) begin
      drive_port(tbl[k].port, tbl[k].adr, tbl[k].dat, tbl[k].we, tbl[k].sel, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("vec%0d_stb%0d", k, i), 96'({m_stb_v[i], m_cyc_v[i], busy_v[i]}), 96'(3'b111));
        chk($sformatf("vec%0d_grant%0d", k, i), 96'(grant_v[i]), 96'(tbl[k].exp_grant));
      end
      chk($sformatf("vec%0d_fields", k), 96'({m_adr_v[0], m_dato_v[0], m_we_v[0], m_sel_v[0]}),
          96'({tbl[k].adr, tbl[k].dat, tbl[k].we, tbl[k].sel}));
      repeat (tbl[k].delay) tick();
      chk($sformatf("vec%0d_hold", k), 96'(m_stb_v[0]), 96'(1));
      m_ack = 1'b1;
      m_dat = tbl[k].rdata;
      #1;
      chk($sformatf("vec%0d_ack", k), 96'({s0_ack_v[0], s1_ack_v[0]}), 96'({tbl[k].exp_ack0, tbl[k].exp_ack1}));
      chk($sformatf("vec%0d_rdata", k), 96'(tbl[k].port ? s1_dato_v[0] : s0_dato_v[0]), 96'(tbl[k].rdata));
      tick();
      m_ack = 1'b0;
      drive_port(tbl[k].port, '0, '0, 1'b0, '0, 1'b0);
      #1;
      chk($sformatf("vec%0d_done", k), 96'({m_stb_v[0], busy_v[0], s0_ack_v[0], s1_ack_v[0]}), 96'(0));
      tick();
    end

    // Both ports requesting continuously, 20 transactions from reset.
    pulse_reset();
    drive_port(1'b0, 30'h0000AAA, 32'h11111111, 1'b0, 4'hF, 1'b1);
    drive_port(1'b1, 30'h0000BBB, 32'h22222222, 1'b1, 4'hC, 1'b1);
    for (int t = 0; t < 20; t++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        eg = (i == 0) ? 1'((t % 2) == 1) : (i == 1) ? 1'((t % 5) == 4) : 1'b0;
        chk($sformatf("cont%0d_stb%0d", t, i), 96'(m_stb_v[i]), 96'(1));
        chk($sformatf("cont%0d_grant%0d", t, i), 96'(grant_v[i]), 96'(eg));
        chk($sformatf("cont%0d_adr%0d", t, i), 96'(m_adr_v[i]), 96'(eg ? 30'h0000BBB : 30'h0000AAA));
      end
      tick();
      m_ack = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
        eg = (i == 0) ? 1'((t % 2) == 1) : (i == 1) ? 1'((t % 5) == 4) : 1'b0;
        chk($sformatf("cont%0d_ack%0d", t, i), 96'({s0_ack_v[i], s1_ack_v[i]}), 96'({!eg, eg}));
      end
      tick();
      m_ack = 1'b0;
      for (int i = 0; i < 3; i++)
        chk($sformatf("cont%0d_gap%0d", t, i), 96'(m_stb_v[i]), 96'(0));
    end
    drive_port(1'b0, '0, '0, 1'b0, '0, 1'b0);
    drive_port(1'b1, '0, '0, 1'b0, '0, 1'b0);
    tick();

    // Port 1 write aborted mid-flight while port 0 waits.
    pulse_reset();
    drive_port(1'b1, 30'h0ABCDEF, 32'hCAFEF00D, 1'b1, 4'h5, 1'b1);
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("abt_grant%0d", i), 96'({m_stb_v[i], grant_v[i]}), 96'(2'b11));
    drive_port(1'b0, 30'h1234567, 32'h0, 1'b0, 4'hF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) s1_cyc = 1'b0;
      tick();
      chk($sformatf("abt_hold%0d", c), 96'({m_stb_v[0], grant_v[0], m_adr_v[0], m_dato_v[0], m_we_v[0], m_sel_v[0]}),
          96'({1'b1, 1'b1, 30'h0ABCDEF, 32'hCAFEF00D, 1'b1, 4'h5}));
    end
    m_ack = 1'b1;
    m_dat = 32'h5555AAAA;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("abt_noack%0d", i), 96'({s0_ack_v[i], s1_ack_v[i]}), 96'(0));
    tick();
    m_ack  = 1'b0;
    s1_stb = 1'b0;
    chk("abt_gap", 96'(m_stb_v[0]), 96'(0));
    tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("abt_next%0d", i), 96'({m_stb_v[i], grant_v[i], m_adr_v[i]}), 96'({1'b1, 1'b0, 30'h1234567}));
    tick();
    m_ack = 1'b1;
    #1;
    chk("abt_p0ack", 96'({s0_ack_v[0], s1_ack_v[0]}), 96'(2'b10));
    tick();
    m_ack = 1'b0;
    drive_port(1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();

    // Reset asserted mid-transaction, then a stray ack in IDLE.
    drive_port(1'b0, 30'h000002A, 32'h1, 1'b0, 4'hF, 1'b1);
    tick();
    chk("mid_busy", 96'({m_stb_v[0], busy_v[0]}), 96'(2'b11));
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("mid_rst%0d", i), 96'({m_stb_v[i], m_cyc_v[i], busy_v[i]}), 96'(0));
    drive_port(1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    m_ack = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("stray_ack%0d", i), 96'({s0_ack_v[i], s1_ack_v[i], busy_v[i]}), 96'(0));
    tick();
    m_ack = 1'b0;

    // Random traffic against the fixed-priority (limit 4) instance.
    pulse_reset();
    prev_stb = 1'b0; prev_ack = 1'b0; cur_port = 1'b0;
    ack_seen0 = 1'b0; ack_seen1 = 1'b0; run0 = 0; wait_cnt = 0; lat = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      r0 = s0_stb & s0_cyc;
      r1 = s1_stb & s1_cyc;
      if (!prev_stb) begin
        chk($sformatf("rnd%0d_req", c), 96'(m_stb_v[1]), 96'(r0 | r1));
        if (m_stb_v[1]) begin
          eg = (r0 && r1) ? (run0 == 4) : r1;
          chk($sformatf("rnd%0d_grant", c), 96'(grant_v[1]), 96'(eg));
          lat = eg ? {s1_adr, s1_dat, s1_we, s1_sel} : {s0_adr, s0_dat, s0_we, s0_sel};
          chk($sformatf("rnd%0d_fields", c), 96'({m_adr_v[1], m_dato_v[1], m_we_v[1], m_sel_v[1]}), 96'(lat));
          run0 = (!eg && r1) ? ((run0 == 4) ? 4 : run0 + 1) : 0;
          cur_port = eg;
        end
      end else if (prev_ack) begin
        chk($sformatf("rnd%0d_gap", c), 96'(m_stb_v[1]), 96'(0));
      end else begin
        chk($sformatf("rnd%0d_hold", c), 96'({m_stb_v[1], m_adr_v[1], m_dato_v[1], m_we_v[1], m_sel_v[1]}),
            96'({1'b1, lat}));
      end
      if (ack_seen0) drive_port(1'b0, '0, '0, 1'b0, '0, 1'b0);
      if (ack_seen1) drive_port(1'b1, '0, '0, 1'b0, '0, 1'b0);
      if (!s0_stb && !ack_seen0 && $urandom_range(0, 2) == 0)
        drive_port(1'b0, 30'($urandom), $urandom, 1'($urandom), 4'($urandom), 1'b1);
      if (!s1_stb && !ack_seen1 && $urandom_range(0, 2) == 0)
        drive_port(1'b1, 30'($urandom), $urandom, 1'($urandom), 4'($urandom), 1'b1);
      m_ack = 1'b0;
      if (m_stb_v[1]) begin
        if (wait_cnt == 0) wait_cnt = int'($urandom_range(1, 4));
        wait_cnt--;
        if (wait_cnt == 0) begin
          m_ack = 1'b1;
          m_dat = $urandom;
        end
      end
      #1;
      a0 = m_ack && !cur_port;
      a1 = m_ack &&  cur_port;
      chk($sformatf("rnd%0d_ack", c), 96'({s0_ack_v[1], s1_ack_v[1]}), 96'({a0, a1}));
      if (a0) chk($sformatf("rnd%0d_d0", c), 96'(s0_dato_v[1]), 96'(m_dat));
      if (a1) chk($sformatf("rnd%0d_d1", c), 96'(s1_dato_v[1]), 96'(m_dat));
      ack_seen0 = a0;
      ack_seen1 = a1;
      prev_stb  = m_stb_v[1];
      prev_ack  = m_ack;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
